// File: rtl/comp2_pkg.sv
// rtl/comp2_pkg.sv - shared constants and state encoding for the comp2 arbiter slice
package comp2_pkg;

    localparam int OPW = 4;
    localparam logic [OPW-1:0] OVF_PATTERN = 4'b1000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/comp2_4bit.sv
// rtl/comp2_4bit.sv - combinational 4-bit two's complement, result mod 16
module comp2_4bit
    import comp2_pkg::*;
(
    input  logic [OPW-1:0] x,
    output logic [OPW-1:0] y
);

    assign y = ~x + OPW'(1);

endmodule

// File: rtl/comp2_rr_arbiter.sv
// rtl/comp2_rr_arbiter.sv - round-robin sharing of one comp2_4bit with a registered result slot
module comp2_rr_arbiter
    import comp2_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [OPW*NREQ-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    output logic [OPW-1:0]      out_data,
    output logic [IDW-1:0]      out_id,
    output logic                out_ovf,
    input  logic                out_ready
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [OPW-1:0]  data_q;
    logic [IDW-1:0]  id_q;
    logic            ovf_q;

    logic            free;
    logic            accept;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic [OPW-1:0]  operand;
    logic [OPW-1:0]  result;

    // A draining consumer frees the slot in the same cycle, giving one result per clock.
    assign free = (state_q == EMPTY) || out_ready;

    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        accept   = 1'b0;
        if (!rst && free) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!accept && req_valid[idx]) begin
                    accept     = 1'b1;
                    grant[idx] = 1'b1;
                    grant_id   = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                operand = req_data[i*OPW +: OPW];
            end
        end
    end

    comp2_4bit u_comp2 (
        .x (operand),
        .y (result)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                data_q <= result;
                id_q   <= grant_id;
                ovf_q  <= (operand == OVF_PATTERN);
            end
        end
    end

    assign req_ready = grant;
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_comp2_rr_arbiter.sv
// tb/tb_comp2_rr_arbiter.sv - directed self-checking bench for comp2_rr_arbiter
module tb_comp2_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ovf;
    logic        out_ready;

    int tests_run;
    int tests_failed;

    comp2_rr_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ovf   (out_ovf),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        req_data = 16'h4321;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_req_ready got %b want 0000", req_ready);
            end
            tick();
        end
        tests_run++;
        if ({out_valid, out_data, out_id, out_ovf} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs got v=%b d=%h id=%0d ovf=%b want all 0",
                     out_valid, out_data, out_id, out_ovf);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_first_grant got %b want 0001", req_ready);
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        req_data = 16'h0300;
        req_valid = 4'b0100;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_grant got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        tests_run++;
        if ({out_valid, out_data, out_id, out_ovf} !== {1'b1, 4'b1101, 2'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_result got v=%b d=%b id=%0d ovf=%b want v=1 d=1101 id=2 ovf=0",
                     out_valid, out_data, out_id, out_ovf);
        end
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_one_cycle got %b want 0000", req_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, out_data, out_id} !== {1'b0, 4'b1101, 2'd2}) begin
            tests_failed++;
            $display("FAIL drain_hold got v=%b d=%b id=%0d want v=0 d=1101 id=2",
                     out_valid, out_data, out_id);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_data [6];
        logic [1:0] exp_id [6];
        logic [3:0] exp_grant [6];
        exp_data  = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hF, 4'hE};
        exp_id    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        out_ready = 1'b1;
        req_data = 16'h4321;
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            tests_run++;
            if (req_ready !== exp_grant[k]) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, exp_grant[k]);
            end
            tick();
            tests_run++;
            if ({out_valid, out_id, out_data} !== {1'b1, exp_id[k], exp_data[k]}) begin
                tests_failed++;
                $display("FAIL rr_result[%0d] got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         k, out_valid, out_id, out_data, exp_id[k], exp_data[k]);
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        req_data = 16'h0750;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests_run++;
            if ({out_valid, out_data, out_id, req_ready} !== {1'b1, 4'b1011, 2'd1, 4'b0000}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d] got v=%b d=%b id=%0d rdy=%b want v=1 d=1011 id=1 rdy=0000",
                         c, out_valid, out_data, out_id, req_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_release_grant got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        tests_run++;
        if ({out_valid, out_data, out_id} !== {1'b1, 4'b1001, 2'd2}) begin
            tests_failed++;
            $display("FAIL bp_next_result got v=%b d=%b id=%0d want v=1 d=1001 id=2",
                     out_valid, out_data, out_id);
        end
        tick();
    endtask

    task automatic test_boundary();
        logic [3:0] exp_data [16];
        exp_data = '{4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9,
                     4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        out_ready = 1'b1;
        for (int x = 0; x < 16; x++) begin
            req_data = {4'(x), 12'h000};
            req_valid = 4'b1000;
            #1;
            tests_run++;
            if (req_ready !== 4'b1000) begin
                tests_failed++;
                $display("FAIL sweep_grant[%0d] got %b want 1000", x, req_ready);
            end
            tick();
            tests_run++;
            if ({out_valid, out_id, out_data, out_ovf} !== {1'b1, 2'd3, exp_data[x], (x == 8)}) begin
                tests_failed++;
                $display("FAIL sweep_result[%0d] got v=%b id=%0d d=%h ovf=%b want v=1 id=3 d=%h ovf=%b",
                         x, out_valid, out_id, out_data, out_ovf, exp_data[x], (x == 8));
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        req_data = 16'h0200;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        tests_run++;
        if ({out_valid, out_id} !== {1'b1, 2'd2}) begin
            tests_failed++;
            $display("FAIL mid_held got v=%b id=%0d want v=1 id=2", out_valid, out_id);
        end
        out_ready = 1'b1;
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_rst_ready got %b want 0000", req_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_discard got v=%b want 0", out_valid);
        end
        rst = 1'b0;
        req_valid = 4'b1010;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL mid_ptr_reset got %b want 0010", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        tests_run++;
        if ({out_valid, out_id} !== {1'b1, 2'd1}) begin
            tests_failed++;
            $display("FAIL mid_first_result got v=%b id=%0d want v=1 id=1", out_valid, out_id);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        req_valid = 4'b0000;
        req_data = 16'h0000;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
